// File: rtl/pueo_trig_queue.sv
// Trigger time-stamp queue: tags accepted triggers with an event number and
// buffers them in a FWFT queue, with a run/flush state machine around it.
module pueo_trig_queue #(
  parameter int unsigned TIME_BITS  = 16,
  parameter int unsigned EVNUM_BITS = 16,
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned HOLDOFF    = 0,
  parameter int unsigned RST_HOLD   = 32
) (
  input  logic                            aclk_i,
  input  logic                            aclk_rst_i,
  input  logic                            run_start_i,
  input  logic                            run_stop_i,
  input  logic                            run_rst_i,
  input  logic [TIME_BITS-1:0]            trig_time_i,
  input  logic                            trig_time_valid_i,
  output logic [EVNUM_BITS+TIME_BITS-1:0] m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            event_rst_o,
  output logic                            running_o,
  output logic [DEPTH_LOG2:0]             count_o,
  output logic [15:0]                     drop_count_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned DW    = EVNUM_BITS + TIME_BITS;
  localparam int unsigned HO_W  = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
  localparam int unsigned RH_W  = (RST_HOLD < 3) ? 1 : $clog2(RST_HOLD);

  localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [HO_W-1:0]     HO_SAT   = HO_W'(HOLDOFF);
  localparam logic [RH_W-1:0]     RH_LAST  = RH_W'((RST_HOLD < 2) ? 0 : RST_HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } state_t;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;

  state_t                  state_q, state_d;
  logic [RH_W-1:0]         hold_q, hold_d;
  logic                    running_q, running_d;
  logic                    event_rst_q, event_rst_d;
  logic [HO_W-1:0]         ho_q, ho_d;
  logic [EVNUM_BITS-1:0]   evnum_q, evnum_d;
  logic [15:0]             drop_q, drop_d;
  ptr_t                    wr_ptr_q, wr_ptr_d;
  ptr_t                    rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic [DW-1:0]           mem_q [DEPTH];

  logic                    in_run;
  logic                    full;
  logic                    empty;
  logic                    holdoff_ok;
  logic                    accept;
  logic                    drop_ev;
  logic                    pop;
  logic                    flush_enter;
  logic [EVNUM_BITS-1:0]   evnum_base;
  logic [15:0]             drop_base;
  logic [DW-1:0]           push_data;

  // Acceptance qualifiers; fullness is judged before any same-cycle pop.
  always_comb begin
    in_run      = (state_q == ST_RUN);
    full        = (count_q == CNT_FULL);
    empty       = (count_q == '0);
    holdoff_ok  = (HOLDOFF == 0) || (ho_q >= HO_SAT);
    accept      = in_run && trig_time_valid_i && !full && holdoff_ok;
    drop_ev     = in_run && trig_time_valid_i && full && holdoff_ok;
    pop         = !empty && m_axis_tready && (state_q != ST_FLUSH);
    flush_enter = in_run && run_stop_i;
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      ST_IDLE: begin
        if (run_start_i && !run_stop_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (run_stop_i) begin
          state_d = ST_FLUSH;
          hold_d  = '0;
        end
      end
      ST_FLUSH: begin
        if (hold_q == RH_LAST) begin
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q + RH_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    running_d   = (state_d == ST_RUN);
    event_rst_d = (state_d == ST_FLUSH);
  end

  // Holdoff counter tracks cycles since the last accept, saturating at HOLDOFF.
  always_comb begin
    ho_d = ho_q;
    if (accept) begin
      ho_d = HO_W'(1);
    end else if (ho_q < HO_SAT) begin
      ho_d = ho_q + HO_W'(1);
    end
  end

  // run_rst clears first so a same-cycle accept is tagged with event 0.
  always_comb begin
    evnum_base = run_rst_i ? '0 : evnum_q;
    drop_base  = run_rst_i ? '0 : drop_q;
    push_data  = {evnum_base, trig_time_i};
    evnum_d    = accept ? evnum_base + EVNUM_BITS'(1) : evnum_base;
    drop_d     = drop_base;
    if (drop_ev && (drop_base != 16'hFFFF)) begin
      drop_d = drop_base + 16'd1;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) begin
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
    unique case ({accept, pop})
      2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
      default: count_d = count_q;
    endcase
    if (flush_enter) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge aclk_i) begin
    if (aclk_rst_i) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      running_q   <= 1'b0;
      event_rst_q <= 1'b0;
      ho_q        <= HO_SAT;
      evnum_q     <= '0;
      drop_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      running_q   <= running_d;
      event_rst_q <= event_rst_d;
      ho_q        <= ho_d;
      evnum_q     <= evnum_d;
      drop_q      <= drop_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage is unreset RAM; the output mux keeps tdata at zero while empty.
  always_ff @(posedge aclk_i) begin
    if (accept && !aclk_rst_i) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign m_axis_tvalid = !empty;
  assign m_axis_tdata  = empty ? '0 : mem_q[rd_ptr_q];
  assign event_rst_o   = event_rst_q;
  assign running_o     = running_q;
  assign count_o       = count_q;
  assign drop_count_o  = drop_q;

endmodule

// File: tb/tb_pueo_trig_queue.sv
// Scoreboard bench for pueo_trig_queue: two instances (small queue, and
// holdoff enabled) share run control; a negedge monitor checks every output word.
module tb_pueo_trig_queue;

  logic        clk;
  logic        rst;
  logic        run_start;
  logic        run_stop;
  logic        run_rst;

  logic [15:0] a_time;
  logic        a_tv;
  logic [31:0] a_tdata;
  logic        a_tvalid;
  logic        a_tready;
  logic        a_event_rst;
  logic        a_running;
  logic [2:0]  a_count;
  logic [15:0] a_drop;

  logic [15:0] b_time;
  logic        b_tv;
  logic [31:0] b_tdata;
  logic        b_tvalid;
  logic        b_tready;
  logic        b_event_rst;
  logic        b_running;
  logic [4:0]  b_count;
  logic [15:0] b_drop;

  int n_cmp;
  int n_bad;
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];

  pueo_trig_queue #(
    .TIME_BITS(16), .EVNUM_BITS(16), .DEPTH_LOG2(2), .HOLDOFF(0), .RST_HOLD(32)
  ) u_dut_a (
    .aclk_i(clk), .aclk_rst_i(rst),
    .run_start_i(run_start), .run_stop_i(run_stop), .run_rst_i(run_rst),
    .trig_time_i(a_time), .trig_time_valid_i(a_tv),
    .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tready(a_tready),
    .event_rst_o(a_event_rst), .running_o(a_running),
    .count_o(a_count), .drop_count_o(a_drop)
  );

  pueo_trig_queue #(
    .TIME_BITS(16), .EVNUM_BITS(16), .DEPTH_LOG2(4), .HOLDOFF(4), .RST_HOLD(32)
  ) u_dut_b (
    .aclk_i(clk), .aclk_rst_i(rst),
    .run_start_i(run_start), .run_stop_i(run_stop), .run_rst_i(run_rst),
    .trig_time_i(b_time), .trig_time_valid_i(b_tv),
    .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tready(b_tready),
    .event_rst_o(b_event_rst), .running_o(b_running),
    .count_o(b_count), .drop_count_o(b_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a word leaves the DUT at the next edge whenever valid and ready are high.
  always @(negedge clk) begin
    if (!rst && a_tvalid && a_tready) begin
      if (exp_a.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL a_out_unexpected: got 0x%0h, required no output", a_tdata);
      end else begin
        chk("a_out", 64'(a_tdata), 64'(exp_a.pop_front()));
      end
    end
    if (!rst && b_tvalid && b_tready) begin
      if (exp_b.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL b_out_unexpected: got 0x%0h, required no output", b_tdata);
      end else begin
        chk("b_out", 64'(b_tdata), 64'(exp_b.pop_front()));
      end
    end
  end

  initial begin
    int hi;
    int cnt_bad;
    logic [15:0] times [3];
    times[0] = 16'h0010;
    times[1] = 16'h0020;
    times[2] = 16'h0030;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    run_start = 1'b0; run_stop = 1'b0; run_rst = 1'b0;
    a_time = '0; a_tv = 1'b0; a_tready = 1'b0;
    b_time = '0; b_tv = 1'b0; b_tready = 1'b1;
    tick();
    tick();

    chk("rst_running", 64'(a_running), 64'd0);
    chk("rst_event_rst", 64'(a_event_rst), 64'd0);
    chk("rst_count", 64'(a_count), 64'd0);
    chk("rst_tvalid", 64'(a_tvalid), 64'd0);
    chk("rst_tdata", 64'(a_tdata), 64'd0);
    chk("rst_drop", 64'(a_drop), 64'd0);
    rst = 1'b0;
    tick();

    // Start and stop together in IDLE: stop wins, stays idle.
    run_start = 1'b1; run_stop = 1'b1;
    tick();
    run_start = 1'b0; run_stop = 1'b0;
    chk("startstop_running", 64'(a_running), 64'd0);
    chk("startstop_evrst", 64'(a_event_rst), 64'd0);

    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    chk("start_running", 64'(a_running), 64'd1);

    // Basic flow.
    a_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_time = times[i];
      a_tv = 1'b1;
      exp_a.push_back({16'(i), times[i]});
      tick();
      chk("basic_tvalid", 64'(a_tvalid), 64'd1);
      chk("basic_tdata", 64'(a_tdata), 64'({16'(i), times[i]}));
      chk("basic_count", 64'(a_count), 64'd1);
    end
    a_tv = 1'b0;
    tick();
    chk("basic_count_end", 64'(a_count), 64'd0);
    chk("basic_drained", 64'(exp_a.size()), 64'd0);

    // Holdoff on instance b: triggers on cycles 0,2,4,5.
    for (int c = 0; c < 6; c++) begin
      b_tv = (c == 0 || c == 2 || c == 4 || c == 5);
      b_time = 16'h0100 + 16'(c);
      if (c == 0) exp_b.push_back({16'd0, 16'h0100});
      if (c == 4) exp_b.push_back({16'd1, 16'h0104});
      tick();
    end
    b_tv = 1'b0;
    tick(); tick(); tick();
    chk("holdoff_drop", 64'(b_drop), 64'd0);
    chk("holdoff_count", 64'(b_count), 64'd0);
    chk("holdoff_drained", 64'(exp_b.size()), 64'd0);

    // run_rst together with a trigger.
    run_rst = 1'b1; a_tv = 1'b1; a_time = 16'h0055;
    exp_a.push_back({16'd0, 16'h0055});
    tick();
    run_rst = 1'b0; a_time = 16'h0066;
    exp_a.push_back({16'd1, 16'h0066});
    tick();
    a_tv = 1'b0;
    tick(); tick();
    chk("runrst_drained", 64'(exp_a.size()), 64'd0);

    // Full queue.
    run_rst = 1'b1;
    tick();
    run_rst = 1'b0;
    a_tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a_tv = 1'b1;
      a_time = 16'h0200 + 16'(i);
      if (i < 4) exp_a.push_back({16'(i), 16'h0200 + 16'(i)});
      tick();
    end
    chk("full_count", 64'(a_count), 64'd4);
    chk("full_drop", 64'(a_drop), 64'd2);
    chk("full_tdata_stable", 64'(a_tdata), 64'({16'd0, 16'h0200}));
    // Full queue with a same-cycle pop still rejects the push.
    a_time = 16'h02FF;
    a_tready = 1'b1;
    tick();
    a_tv = 1'b0;
    chk("full_pop_count", 64'(a_count), 64'd3);
    chk("full_pop_drop", 64'(a_drop), 64'd3);
    for (int k = 0; k < 5; k++) tick();
    chk("full_count_end", 64'(a_count), 64'd0);
    chk("full_drained", 64'(exp_a.size()), 64'd0);

    // Stop with three entries queued.
    a_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_tv = 1'b1;
      a_time = 16'h0300 + 16'(i);
      tick();
    end
    a_tv = 1'b0;
    chk("flush_pre_count", 64'(a_count), 64'd3);
    run_stop = 1'b1;
    tick();
    run_stop = 1'b0;
    exp_a.delete();
    exp_b.delete();
    chk("flush_count", 64'(a_count), 64'd0);
    chk("flush_tvalid", 64'(a_tvalid), 64'd0);
    chk("flush_evrst", 64'(a_event_rst), 64'd1);
    chk("flush_running", 64'(a_running), 64'd0);
    a_tv = 1'b1;
    a_time = 16'h0BAD;
    a_tready = 1'b1;
    hi = 1;
    cnt_bad = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (a_count != 0) cnt_bad++;
      if (!a_event_rst) break;
      hi++;
    end
    chk("flush_len", 64'(hi), 64'd32);
    chk("flush_trig_ignored", 64'(cnt_bad), 64'd0);
    chk("flush_idle_running", 64'(a_running), 64'd0);
    tick();
    chk("idle_trig_ignored", 64'(a_count), 64'd0);
    chk("idle_drop_kept", 64'(a_drop), 64'd3);
    a_tv = 1'b0;

    // Event number continues across a flush.
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    a_tv = 1'b1;
    a_time = 16'h0400;
    exp_a.push_back({16'd7, 16'h0400});
    tick();
    a_tv = 1'b0;
    tick(); tick();
    chk("restart_drained", 64'(exp_a.size()), 64'd0);

    // Drop counter saturation.
    run_rst = 1'b1;
    tick();
    run_rst = 1'b0;
    a_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_tv = 1'b1;
      a_time = 16'h0600 + 16'(i);
      exp_a.push_back({16'(i), 16'h0600 + 16'(i)});
      tick();
    end
    a_time = 16'h06FF;
    for (int k = 0; k < 65540; k++) tick();
    a_tv = 1'b0;
    chk("sat_drop", 64'(a_drop), 64'hFFFF);
    chk("sat_count", 64'(a_count), 64'd4);

    // Reset in the middle of a flush.
    run_stop = 1'b1;
    tick();
    run_stop = 1'b0;
    exp_a.delete();
    for (int k = 0; k < 5; k++) tick();
    chk("midflush_evrst_pre", 64'(a_event_rst), 64'd1);
    rst = 1'b1;
    tick();
    chk("midflush_evrst", 64'(a_event_rst), 64'd0);
    chk("midflush_running", 64'(a_running), 64'd0);
    chk("midflush_count", 64'(a_count), 64'd0);
    chk("midflush_tvalid", 64'(a_tvalid), 64'd0);
    chk("midflush_tdata", 64'(a_tdata), 64'd0);
    chk("midflush_drop", 64'(a_drop), 64'd0);
    rst = 1'b0;
    tick();

    // Event number restarts at 0 after reset.
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    a_tready = 1'b1;
    a_tv = 1'b1;
    a_time = 16'h0700;
    exp_a.push_back({16'd0, 16'h0700});
    tick();
    a_tv = 1'b0;
    tick(); tick(); tick();
    chk("final_a_drained", 64'(exp_a.size()), 64'd0);
    chk("final_b_drained", 64'(exp_b.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
